// File: rtl/rr_mux_arbiter_4.sv
// Four-way round-robin arbiter feeding a single registered output stage.
// The grant search starts at ptr and moves to the requester after the last winner.
module rr_mux_arbiter_4 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel
);

  logic [1:0]   ptr_q, ptr_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [1:0]   out_sel_q, out_sel_d;

  logic         load_en;
  logic         gnt_found;
  logic [1:0]   gnt_idx;
  logic [1:0]   search_idx;
  logic [W-1:0] gnt_data;

  // The output register can take a beat when empty or when it drains this cycle.
  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    gnt_found  = 1'b0;
    gnt_idx    = ptr_q;
    search_idx = ptr_q;
    for (int k = 0; k < 4; k++) begin
      search_idx = ptr_q + 2'(k);
      if (!gnt_found && in_valid[search_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = search_idx;
      end
    end
  end

  always_comb begin
    gnt_data = in_data0;
    unique case (gnt_idx)
      2'd0: gnt_data = in_data0;
      2'd1: gnt_data = in_data1;
      2'd2: gnt_data = in_data2;
      2'd3: gnt_data = in_data3;
      default: gnt_data = in_data0;
    endcase
  end

  // Gated by rst_n so no requester sees an accept while reset is held.
  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && load_en && gnt_found) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      if (gnt_found) begin
        out_valid_d = 1'b1;
        out_data_d  = gnt_data;
        out_sel_d   = gnt_idx;
        ptr_d       = gnt_idx + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Self-checking bench for rr_mux_arbiter_4: directed scenarios plus a long random run,
// with accepted beats queued at the input and compared when they leave the output.
module tb_rr_mux_arbiter_4;

  localparam int unsigned W = 4;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [W-1:0] dat [4];
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;

  int n_total;
  int n_bad;

  beat_t      sb [$];
  logic [1:0] m_ptr;
  logic       m_ov;
  logic [3:0] acc;
  int         wait_cnt [4];
  logic [W-1:0] rot [4];

  rr_mux_arbiter_4 #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data0 (dat[0]),
    .in_data1 (dat[1]),
    .in_data2 (dat[2]),
    .in_data3 (dat[3]),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 2'd0;
    m_ov  = 1'b0;
    acc   = 4'b0000;
    sb.delete();
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  // Inputs are already driven; sample at the falling edge, then advance past the rising edge.
  task automatic cycle();
    logic       le;
    logic       found;
    logic [1:0] g;
    logic [3:0] er;
    logic [3:0] rot_v;
    beat_t      b;
    @(negedge clk);
    le    = !m_ov || out_ready;
    found = 1'b0;
    g     = 2'd0;
    // Rotate valid so bit 0 corresponds to ptr, then take the lowest set bit.
    rot_v = (in_valid >> m_ptr) | (in_valid << (3'd4 - {1'b0, m_ptr}));
    for (int k = 3; k >= 0; k--) begin
      if (rot_v[k]) begin
        found = 1'b1;
        g     = m_ptr + 2'(k);
      end
    end
    er = (le && found) ? (4'b0001 << g) : 4'b0000;
    check_eq("in_ready", {28'd0, in_ready}, {28'd0, er});
    check_eq("onehot0", {31'd0, $onehot0(in_ready)}, 32'd1);
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov && sb.size() > 0) begin
      check_eq("out_data", {28'd0, out_data}, {28'd0, sb[0].data});
      check_eq("out_sel", {30'd0, out_sel}, {30'd0, sb[0].sel});
    end
    acc = er;
    if (le) begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i]) begin
          if (er[i]) begin
            check_eq("starve", {31'd0, (wait_cnt[i] <= 3)}, 32'd1);
            wait_cnt[i] = 0;
          end else begin
            wait_cnt[i]++;
          end
        end
      end
    end
    if (m_ov && out_ready) void'(sb.pop_front());
    if (le) begin
      if (found) begin
        b.sel  = g;
        b.data = dat[g];
        sb.push_back(b);
        m_ptr = g + 2'd1;
        m_ov  = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rot[0]    = 4'h3;
    rot[1]    = 4'h5;
    rot[2]    = 4'h9;
    rot[3]    = 4'hC;
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = rot[i];
    model_reset();

    // Reset state, with requests already pending.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {28'd0, in_ready}, 32'd0);
    check_eq("rst_out_sel", {30'd0, out_sel}, 32'd0);
    check_eq("rst_out_data", {28'd0, out_data}, 32'd0);
    rst_n = 1'b1;

    // Rotation 0,1,2,3,0 with no bubbles.
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_eq("rot_valid", {31'd0, out_valid}, 32'd1);
      check_eq("rot_sel", {30'd0, out_sel}, k % 4);
      check_eq("rot_data", {28'd0, out_data}, {28'd0, rot[k % 4]});
    end

    // Backpressure holding beat (0,3); ptr is now 1.
    out_ready = 1'b0;
    in_valid  = 4'b0110;
    dat[1]    = 4'h6;
    dat[2]    = 4'h7;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("bp_in_ready", {28'd0, in_ready}, 32'd0);
      cycle();
      check_eq("bp_data", {28'd0, out_data}, 32'h3);
      check_eq("bp_sel", {30'd0, out_sel}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", {28'd0, in_ready}, 32'b0010);
    cycle();
    check_eq("bp_next_sel", {30'd0, out_sel}, 32'd1);
    check_eq("bp_next_data", {28'd0, out_data}, 32'h6);
    in_valid = 4'b0100;
    cycle();
    check_eq("bp_after_sel", {30'd0, out_sel}, 32'd2);

    // Skip: ptr goes to 1 via requester 0, then requester 0 alone is granted with ptr at 1.
    in_valid = 4'b0001;
    dat[0]   = 4'hE;
    cycle();
    check_eq("skip_first_sel", {30'd0, out_sel}, 32'd0);
    dat[0] = 4'h1;
    cycle();
    check_eq("skip_sel", {30'd0, out_sel}, 32'd0);
    check_eq("skip_data", {28'd0, out_data}, 32'h1);
    in_valid = 4'b0011;
    dat[0]   = 4'h2;
    dat[1]   = 4'h8;
    #1;
    check_eq("skip_ptr_kept", {28'd0, in_ready}, 32'b0010);
    cycle();
    in_valid = 4'b0001;
    cycle();
    check_eq("skip_wrap_sel", {30'd0, out_sel}, 32'd0);

    // Idle drain after one beat from requester 3.
    in_valid = 4'b1000;
    dat[3]   = 4'hA;
    cycle();
    check_eq("idle_valid1", {31'd0, out_valid}, 32'd1);
    check_eq("idle_sel1", {30'd0, out_sel}, 32'd3);
    in_valid = 4'b0000;
    cycle();
    check_eq("idle_valid0", {31'd0, out_valid}, 32'd0);
    check_eq("idle_sel_hold", {30'd0, out_sel}, 32'd3);
    check_eq("idle_data_hold", {28'd0, out_data}, 32'hA);

    // Reset mid-stream with a beat stalled in the output register.
    in_valid  = 4'b0100;
    dat[2]    = 4'h5;
    out_ready = 1'b0;
    cycle();
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_data", {28'd0, out_data}, 32'd0);
    check_eq("mid_rst_sel", {30'd0, out_sel}, 32'd0);
    check_eq("mid_rst_ready", {28'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    dat[1]    = 4'h2;
    #1;
    check_eq("post_rst_ready", {28'd0, in_ready}, 32'b0010);
    cycle();
    check_eq("post_rst_sel", {30'd0, out_sel}, 32'd1);
    check_eq("post_rst_data", {28'd0, out_data}, 32'h2);
    in_valid = in_valid & ~acc;

    // Random traffic; requesters hold valid and data until accepted.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!in_valid[i] && ($urandom_range(0, 1) == 1)) begin
          in_valid[i] = 1'b1;
          dat[i]      = W'($urandom_range(0, 15));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      in_valid = in_valid & ~acc;
    end

    in_valid  = 4'b0000;
    out_ready = 1'b1;
    repeat (3) cycle();
    check_eq("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
